// File: rtl/core_defs.sv
// Core-wide constants shared by the decoder, write-back mux, ALU operand muxes and register file.
package core_defs;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = $clog2(NUM_REGS);
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: NUM_REGS:1 mux, x0 zero override and, with REGFILE_BYPASS_EN
// defined, write-through forwarding of the same-cycle write-back value.
module regfile_read_port
    import core_defs::*;
#(
    parameter int DATA_W   = core_defs::DATA_W,
    parameter int NUM_REGS = core_defs::NUM_REGS,
    parameter int ADDR_W   = core_defs::ADDR_W
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               raddr,
    input  logic                            we,
    input  logic [ADDR_W-1:0]               waddr,
    input  logic [DATA_W-1:0]               wdata,
    output logic [DATA_W-1:0]               rdata
);

`ifndef REGFILE_BYPASS_EN
    // Write-port signals only feed the forwarding compare; tie them off in the plain build.
    logic unused_bypass;
    assign unused_bypass = ^{we, waddr, wdata};
`endif

    // NOTE: rdata gets a default before any conditional override so no latch is inferred.
    always_comb begin
        rdata = regs[raddr];
`ifdef REGFILE_BYPASS_EN
        if (we && (waddr != ADDR_W'(REG_ZERO)) && (raddr == waddr)) begin
            rdata = wdata;
        end
`endif
        // x0 wins over storage and forwarding alike.
        if (raddr == ADDR_W'(REG_ZERO)) begin
            rdata = '0;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Architectural integer register file: one synchronous write port, two combinational read ports,
// x0 hardwired to zero. Define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module reg_file
    import core_defs::*;
#(
    parameter int DATA_W   = core_defs::DATA_W,
    parameter int NUM_REGS = core_defs::NUM_REGS,
    parameter int ADDR_W   = core_defs::ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;

    // NOTE: every entry is reset because the core relies on defined register values from
    // reset onward; this keeps the array in flops rather than a RAM macro.
    // NOTE: state is updated with non-blocking assignments so reads in the same edge see old values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we && (waddr != ADDR_W'(REG_ZERO))) begin
            mem[waddr] <= wdata;
        end
    end

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd1 (
        .regs  (mem),
        .raddr (raddr1),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata1)
    );

    regfile_read_port #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_rd2 (
        .regs  (mem),
        .raddr (raddr2),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .rdata (rdata2)
    );

endmodule
